uart_autobaud_ctrl: RTL



---
 rtl/uart_autobaud_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud calibration: times a received 0x55 sync character and programs the
// baud generator's clock_divide for a 2^OVS_LOG2 oversampled receive tick.
module uart_autobaud_ctrl #(
  parameter int          OVS_LOG2       = 4,
  parameter int          CNT_W          = 24,
  parameter logic [15:0] DEFAULT_DIVIDE = 16'd26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx,
  output logic [15:0] clock_divide,
  output logic        baud_enable,
  output logic        busy,
  output logic        locked,
  output logic        error
);

  // Edge 1 to edge 5 of 0x55 spans 8 bit times, hence the extra 3 in the shift.
  localparam int              SHIFT   = 3 + OVS_LOG2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_EDGE,
    ST_MEASURE,
    ST_CALC,
    ST_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic               rx_q, rx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [15:0]        clock_divide_q, clock_divide_d;
  logic               baud_enable_q, baud_enable_d;
  logic               busy_q, busy_d;
  logic               locked_q, locked_d;
  logic               error_q, error_d;
  logic               fall;
  logic [31:0]        quot;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      rx_q           <= 1'b1;
      cnt_q          <= '0;
      edge_cnt_q     <= '0;
      n_q            <= '0;
      clock_divide_q <= DEFAULT_DIVIDE;
      baud_enable_q  <= 1'b1;
      busy_q         <= 1'b0;
      locked_q       <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      rx_q           <= rx_d;
      cnt_q          <= cnt_d;
      edge_cnt_q     <= edge_cnt_d;
      n_q            <= n_d;
      clock_divide_q <= clock_divide_d;
      baud_enable_q  <= baud_enable_d;
      busy_q         <= busy_d;
      locked_q       <= locked_d;
      error_q        <= error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rx_d           = rx;
    cnt_d          = cnt_q;
    edge_cnt_d     = edge_cnt_q;
    n_d            = n_q;
    clock_divide_d = clock_divide_q;
    baud_enable_d  = baud_enable_q;
    busy_d         = busy_q;
    locked_d       = locked_q;
    error_d        = error_q;
    fall           = rx_q & ~rx;
    quot           = 32'(n_q) >> SHIFT;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_WAIT_EDGE;
          cnt_d         = '0;
          edge_cnt_d    = '0;
          busy_d        = 1'b1;
          baud_enable_d = 1'b0;
          locked_d      = 1'b0;
          error_d       = 1'b0;
        end
      end

      ST_WAIT_EDGE: begin
        if (fall) begin
          cnt_d      = CNT_W'(1);
          edge_cnt_d = 3'd1;
          state_d    = ST_MEASURE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_FAIL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_MEASURE: begin
        if (fall && (edge_cnt_q == 3'd4)) begin
          n_d        = cnt_q;
          edge_cnt_d = 3'd5;
          state_d    = ST_CALC;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_FAIL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (fall) begin
            edge_cnt_d = edge_cnt_q + 3'd1;
          end
        end
      end

      ST_CALC: begin
        // Zero means the line is faster than one tick per cycle; above 2^16 will not fit the divider.
        if ((quot == 32'd0) || (quot > 32'd65536)) begin
          state_d = ST_FAIL;
        end else begin
          clock_divide_d = 16'(quot - 32'd1);
          baud_enable_d  = 1'b1;
          locked_d       = 1'b1;
          busy_d         = 1'b0;
          state_d        = ST_IDLE;
        end
      end

      ST_FAIL: begin
        error_d       = 1'b1;
        busy_d        = 1'b0;
        baud_enable_d = 1'b1;
        state_d       = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign clock_divide = clock_divide_q;
  assign baud_enable  = baud_enable_q;
  assign busy         = busy_q;
  assign locked       = locked_q;
  assign error        = error_q;

endmodule
